// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 definitions for the host transmitter and keyboard receiver
//   ps2_state_t      host transmitter FSM states
//   PS2_FRAME_BITS   bits clocked out after the start bit (8 data, parity, stop)
//   PS2_CMD_*        common host-to-keyboard command bytes
//   ps2_frame()      builds {stop, odd parity, data} for shifting out LSB first
package ps2_pkg;
   typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAITIDLE} ps2_state_t;
   localparam int PS2_FRAME_BITS = 10;
   localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
   function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
      return {1'b1, ~^b, b};
   endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizer for one PS/2 pad plus a falling-edge strobe
//   clk, rst  system clock, asynchronous active-high reset
//   pad       raw asynchronous pad level
//   lvl       synchronized level (resets high, the idle bus level)
//   fe        one-cycle strobe on a synchronized high-to-low transition
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic pad,
   output logic lvl,
   output logic fe
);
   logic s1, prev;
   always_ff @(posedge clk or posedge rst)
      if (rst) {s1, lvl, prev} <= 3'b111;
      else     {s1, lvl, prev} <= {pad, s1, lvl};
   assign fe = prev & ~lvl;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with open-drain enables
//   clk_i, rst_i          system clock, asynchronous active-high reset
//   tx_data, tx_valid     command byte and request, taken when tx_valid & tx_ready
//   tx_ready, busy        ready only while idle; busy is its complement
//   done, err             one-cycle completion pulse; err flags NACK or timeout
//   ps2clk_i, ps2data_i   raw pad levels
//   ps2clk_oe, ps2data_oe 1 pulls the corresponding line low
// Build option PS2_TX_RETRY_EN: the first NACK/timeout silently restarts the
// transfer with the same byte; only a second failure is reported.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 4000,
   parameter int TIMEOUT_CYCLES = 600000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       done,
   output logic       err,
   output logic       busy,
   input  logic       ps2clk_i,
   input  logic       ps2data_i,
   output logic       ps2clk_oe,
   output logic       ps2data_oe
);
   localparam int CW = $clog2((TIMEOUT_CYCLES > INHIBIT_CYCLES ? TIMEOUT_CYCLES : INHIBIT_CYCLES) + 1) + 1;
   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
   ps2_state_t state, state_n;
   logic [7:0] data_q, data_n;
   logic [PS2_FRAME_BITS-1:0] frame, frame_n;
   logic [3:0] bitcnt, bitcnt_n;
   logic [CW-1:0] cnt, cnt_n;
   logic dat, dat_n, ack, ack_n, fin, bad;
   logic clk_lvl, clk_fe, data_lvl;
   ps2_line_sync u_clk (.clk(clk_i), .rst(rst_i), .pad(ps2clk_i), .lvl(clk_lvl), .fe(clk_fe));
   ps2_line_sync u_data (.clk(clk_i), .rst(rst_i), .pad(ps2data_i), .lvl(data_lvl), .fe());
`ifdef PS2_TX_RETRY_EN
   logic retry, retry_n;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) retry <= 1'b0;
      else       retry <= retry_n;
`endif
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state  <= IDLE;
         data_q <= '0;
         frame  <= '0;
         bitcnt <= '0;
         cnt    <= '0;
         dat    <= 1'b0;
         ack    <= 1'b0;
      end else begin
         state  <= state_n;
         data_q <= data_n;
         frame  <= frame_n;
         bitcnt <= bitcnt_n;
         cnt    <= cnt_n;
         dat    <= dat_n;
         ack    <= ack_n;
      end
   // cnt holds (cycles since the last clear) - 1, so expiry lands exactly
   // TIMEOUT_CYCLES cycles after the last device clock strobe.
   always_comb begin
      state_n  = state;
      data_n   = data_q;
      frame_n  = frame;
      bitcnt_n = bitcnt;
      cnt_n    = cnt + 1'b1;
      dat_n    = dat;
      ack_n    = ack;
      fin      = 1'b0;
      bad      = 1'b0;
      case (state)
         IDLE:
            if (tx_valid) begin
               state_n  = INHIBIT;
               data_n   = tx_data;
               frame_n  = ps2_frame(tx_data);
               bitcnt_n = '0;
               cnt_n    = '0;
            end
         // The frame is rebuilt from the held byte so a retry resends it intact.
         INHIBIT:
            if (cnt == INH_LAST) begin
               state_n  = RTS;
               frame_n  = ps2_frame(data_q);
               bitcnt_n = '0;
            end
         RTS: begin
            state_n = SEND;
            cnt_n   = '0;
            dat_n   = 1'b1;
         end
         SEND:
            if (clk_fe) begin
               cnt_n    = '0;
               dat_n    = ~frame[0];
               frame_n  = frame >> 1;
               bitcnt_n = bitcnt + 1'b1;
               if (bitcnt == 4'(PS2_FRAME_BITS - 1)) state_n = ACK;
            end else if (cnt == TO_LAST) {fin, bad} = 2'b11;
         ACK:
            if (clk_fe) begin
               cnt_n   = '0;
               ack_n   = ~data_lvl;
               state_n = WAITIDLE;
            end else if (cnt == TO_LAST) {fin, bad} = 2'b11;
         WAITIDLE:
            if (clk_lvl & data_lvl) {fin, bad} = {1'b1, ~ack};
            else if (clk_fe) cnt_n = '0;
            else if (cnt == TO_LAST) {fin, bad} = 2'b11;
         default: state_n = IDLE;
      endcase
      done = fin;
      err  = fin & bad;
      if (fin) state_n = IDLE;
`ifdef PS2_TX_RETRY_EN
      retry_n = (state == IDLE) ? 1'b0 : retry;
      if (fin & bad & ~retry) begin
         state_n = INHIBIT;
         cnt_n   = '0;
         retry_n = 1'b1;
         done    = 1'b0;
         err     = 1'b0;
      end
`endif
   end
   assign tx_ready   = (state == IDLE);
   assign busy       = ~tx_ready;
   assign ps2clk_oe  = (state == INHIBIT) | (state == RTS);
   assign ps2data_oe = (state == RTS) | ((state == SEND) & dat);
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized self-checking bench with a behavioural PS/2 device
module tb_ps2_host_tx;
   localparam int INH = 8, TO = 200, HALF = 20;
`ifdef PS2_TX_RETRY_EN
   localparam int ATT = 2;
`else
   localparam int ATT = 1;
`endif
   logic clk = 1'b0, rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic tx_valid = 1'b0;
   logic tx_ready, done, err, busy, ps2clk_oe, ps2data_oe;
   logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
   logic ps2clk, ps2data;
   int errors = 0, checks = 0, cyc = 0, done_cnt = 0, acc_cnt = 0, done_cyc = 0, last_fall = 0;
   logic last_err = 1'b0, done_oe = 1'b0;

   assign ps2clk  = ~(ps2clk_oe | dev_clk_low);
   assign ps2data = ~(ps2data_oe | dev_data_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .rst_i(rst), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .done(done), .err(err), .busy(busy),
      .ps2clk_i(ps2clk), .ps2data_i(ps2data),
      .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (done) begin
         done_cnt <= done_cnt + 1;
         last_err <= err;
         done_cyc <= cyc;
         done_oe  <= ps2clk_oe | ps2data_oe;
      end
      if (tx_valid & tx_ready & ~rst) acc_cnt <= acc_cnt + 1;
   end

   // Expected 10 bits seen by the device after the start bit: data LSB first,
   // odd parity (parity bit makes the total count of ones odd), stop = 1.
   function automatic logic [9:0] model(input logic [7:0] b);
      int ones;
      ones = $countones(b);
      for (int i = 0; i < 8; i++) model[i] = b[i];
      model[8] = (ones % 2 == 0);
      model[9] = 1'b1;
   endfunction

   task automatic start(input logic [7:0] b);
      @(posedge clk); #1;
      tx_data = b;
      tx_valid = 1'b1;
      @(posedge clk); #1;
      tx_valid = 1'b0;
   endtask

   // Device side: waits for the host request, measures inhibit/RTS lengths,
   // then generates nclk clock pulses, sampling data on each rising edge.
   task automatic device_frame(input int nclk, input bit nack, output int inh, output int rts,
                               output logic [9:0] got, output logic start_bit);
      int guard;
      guard = 0;
      inh = 0;
      rts = 0;
      got = '0;
      do begin
         @(negedge clk);
         guard++;
      end while (!ps2clk_oe && guard < 2000);
      while (ps2clk_oe && !ps2data_oe && inh < 2000) begin
         inh++;
         @(negedge clk);
      end
      while (ps2clk_oe && ps2data_oe && rts < 2000) begin
         rts++;
         @(negedge clk);
      end
      start_bit = ps2data;
      @(posedge clk); #1;
      for (int i = 0; i < nclk; i++) begin
         repeat (HALF) @(posedge clk);
         #1 dev_clk_low = 1'b1;
         last_fall = cyc;
         repeat (HALF) @(posedge clk);
         #1 dev_clk_low = 1'b0;
         if (i < 10) got[i] = ps2data;
         if (i == 9 && !nack) dev_data_low = 1'b1;
         if (i == 10) dev_data_low = 1'b0;
      end
   endtask

   task automatic wait_done(input int base, output bit ok);
      int n;
      n = 0;
      while (done_cnt <= base && n < 1000) begin
         @(negedge clk);
         n++;
      end
      ok = (done_cnt > base);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (ps2clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b want 0", ps2clk_oe); end
      checks++; if (ps2data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b want 0", ps2data_oe); end
      checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b%b want 00", done, err); end
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_send_ed();
      int inh, rts, b0;
      logic [9:0] got;
      logic st;
      bit ok;
      b0 = done_cnt;
      start(8'hED);
      device_frame(11, 0, inh, rts, got, st);
      wait_done(b0, ok);
      checks++; if (inh !== INH) begin errors++; $display("FAIL ed_inhibit_len: got %0d want %0d", inh, INH); end
      checks++; if (rts !== 1) begin errors++; $display("FAIL ed_rts_len: got %0d want 1", rts); end
      checks++; if (st !== 1'b0) begin errors++; $display("FAIL ed_start_bit: got %b want 0", st); end
      checks++; if (got !== model(8'hED)) begin errors++; $display("FAIL ed_bits: got %b want %b", got, model(8'hED)); end
      checks++; if (!ok || last_err !== 1'b0) begin errors++; $display("FAIL ed_done_err: done_seen=%0d err=%b want 1/0", ok, last_err); end
      repeat (50) @(negedge clk);
      checks++; if (done_cnt !== b0 + 1) begin errors++; $display("FAIL ed_done_once: got %0d want %0d", done_cnt - b0, 1); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ed_busy_after: got %b want 0", busy); end
   endtask

   task automatic test_random();
      int inh, rts, b0;
      logic [9:0] got;
      logic [7:0] b;
      logic st;
      bit ok;
      for (int k = 0; k < 4; k++) begin
         b = 8'($urandom_range(0, 255));
         b0 = done_cnt;
         start(b);
         device_frame(11, 0, inh, rts, got, st);
         wait_done(b0, ok);
         checks++; if (got !== model(b) || inh !== INH) begin errors++; $display("FAIL rand_bits[%0d]: byte %h got %b inh %0d want %b inh %0d", k, b, got, inh, model(b), INH); end
         checks++; if (!ok || last_err !== 1'b0) begin errors++; $display("FAIL rand_done[%0d]: done_seen=%0d err=%b want 1/0", k, ok, last_err); end
         repeat (10) @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int inh1, rts1, inh2, rts2, b0, a0, d_at_second;
      logic [9:0] g1, g2;
      logic s1, s2;
      bit ok;
      b0 = done_cnt;
      a0 = acc_cnt;
      d_at_second = -1;
      @(posedge clk); #1;
      tx_data = 8'hF4;
      tx_valid = 1'b1;
      @(posedge clk); #1;
      tx_data = 8'h00;
      fork
         begin
            device_frame(11, 0, inh1, rts1, g1, s1);
            device_frame(11, 0, inh2, rts2, g2, s2);
         end
         begin
            int n;
            n = 0;
            while (acc_cnt < a0 + 2 && n < 4000) begin
               @(negedge clk);
               n++;
            end
            @(posedge clk); #1;
            tx_valid = 1'b0;
            d_at_second = done_cnt - b0;
         end
      join
      wait_done(b0 + 1, ok);
      checks++; if (g1 !== model(8'hF4)) begin errors++; $display("FAIL b2b_first_bits: got %b want %b", g1, model(8'hF4)); end
      checks++; if (g2 !== model(8'h00) || inh2 !== INH) begin errors++; $display("FAIL b2b_second_bits: got %b inh %0d want %b inh %0d", g2, inh2, model(8'h00), INH); end
      checks++; if (d_at_second !== 1) begin errors++; $display("FAIL b2b_order: dones before second accept %0d want 1", d_at_second); end
      checks++; if (!ok || last_err !== 1'b0) begin errors++; $display("FAIL b2b_err: done_seen=%0d err=%b want 1/0", ok, last_err); end
      repeat (50) @(negedge clk);
      checks++; if (done_cnt !== b0 + 2 || acc_cnt !== a0 + 2) begin errors++; $display("FAIL b2b_counts: dones %0d accepts %0d want 2/2", done_cnt - b0, acc_cnt - a0); end
   endtask

   task automatic test_nack();
      int inh, rts, b0, ninh;
      logic [9:0] got;
      logic st;
      bit ok;
      b0 = done_cnt;
      ninh = 0;
      start(8'hF4);
      for (int a = 0; a < ATT; a++) begin
         device_frame(11, 1, inh, rts, got, st);
         if (inh == INH) ninh++;
      end
      wait_done(b0, ok);
      checks++; if (!ok || last_err !== 1'b1) begin errors++; $display("FAIL nack_err: done_seen=%0d err=%b want 1/1", ok, last_err); end
      checks++; if (ninh !== ATT) begin errors++; $display("FAIL nack_attempts: full inhibits %0d want %0d", ninh, ATT); end
      repeat (50) @(negedge clk);
      checks++; if (done_cnt !== b0 + 1) begin errors++; $display("FAIL nack_done_once: got %0d want 1", done_cnt - b0); end
   endtask

   // Stalled device: done must land TO cycles after the synchronized strobe,
   // which itself trails the pad fall by the two synchronizer stages.
   task automatic test_timeout();
      int inh, rts, b0;
      logic [9:0] got;
      logic st;
      bit ok;
      b0 = done_cnt;
      start(8'h5A);
      for (int a = 0; a < ATT; a++) device_frame(4, 0, inh, rts, got, st);
      wait_done(b0, ok);
      checks++; if (!ok || last_err !== 1'b1) begin errors++; $display("FAIL to_err: done_seen=%0d err=%b want 1/1", ok, last_err); end
      checks++; if (done_cyc - last_fall !== TO + 2) begin errors++; $display("FAIL to_latency: got %0d want %0d", done_cyc - last_fall, TO + 2); end
      checks++; if (done_oe !== 1'b0) begin errors++; $display("FAIL to_release: oe at done %b want 0", done_oe); end
      checks++; if (got[3:0] !== 4'hA) begin errors++; $display("FAIL to_partial_bits: got %h want a", got[3:0]); end
      repeat (20) @(negedge clk);
      checks++; if (done_cnt !== b0 + 1 || tx_ready !== 1'b1) begin errors++; $display("FAIL to_final: dones %0d ready %b want 1/1", done_cnt - b0, tx_ready); end
   endtask

   task automatic test_reset_mid();
      int inh, rts, b0;
      logic [9:0] got;
      logic st;
      bit ok;
      b0 = done_cnt;
      start(8'h00);
      device_frame(3, 0, inh, rts, got, st);
      checks++; if (ps2data_oe !== 1'b1) begin errors++; $display("FAIL rstmid_pre: data_oe %b want 1", ps2data_oe); end
      #2 rst = 1'b1;
      #1;
      checks++; if (ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b0) begin errors++; $display("FAIL rstmid_release: oe %b%b want 00", ps2clk_oe, ps2data_oe); end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", tx_ready); end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (TO + 100) @(negedge clk);
      checks++; if (done_cnt !== b0) begin errors++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt - b0); end
      start(8'hFF);
      device_frame(11, 0, inh, rts, got, st);
      wait_done(b0, ok);
      checks++; if (got !== model(8'hFF) || !ok || last_err !== 1'b0) begin errors++; $display("FAIL rstmid_resend: bits %b done_seen=%0d err=%b want %b 1 0", got, ok, last_err, model(8'hFF)); end
   endtask

   task automatic test_busy_ignore();
      int inh, rts, b0, a0;
      logic [9:0] got;
      logic [7:0] b;
      logic st;
      bit ok;
      b = 8'($urandom_range(0, 255));
      b0 = done_cnt;
      a0 = acc_cnt;
      start(b);
      fork
         device_frame(11, 0, inh, rts, got, st);
         begin
            repeat (3) @(posedge clk);
            #1 tx_valid = 1'b1;
            tx_data = ~b;
            @(posedge clk); #1 tx_valid = 1'b0;
            repeat (100) @(posedge clk);
            #1 tx_valid = 1'b1;
            tx_data = b ^ 8'h5A;
            @(posedge clk); #1 tx_valid = 1'b0;
         end
      join
      wait_done(b0, ok);
      repeat (50) @(negedge clk);
      checks++; if (got !== model(b) || inh !== INH) begin errors++; $display("FAIL busy_bits: got %b inh %0d want %b inh %0d", got, inh, model(b), INH); end
      checks++; if (acc_cnt !== a0 + 1 || done_cnt !== b0 + 1) begin errors++; $display("FAIL busy_counts: accepts %0d dones %0d want 1/1", acc_cnt - a0, done_cnt - b0); end
   endtask

   initial begin
      test_reset();
      test_send_ed();
      test_random();
      test_back_to_back();
      test_nack();
      test_timeout();
      test_reset_mid();
      test_busy_ignore();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end
endmodule
